rca_seq_arbiter: RTL and testbench

Controller that shares one external N-bit ripple-carry adder between two requesters and sequences multi-word additions through it. Each request carries WORDS×N-bit operands. The block feeds them to the adder one N-bit word per cycle, least-significant word first, and chains the carry between words. It then returns the full-width sum and final carry on a response handshake. It sits between the adder datapath and its clients, which therefore need no adder of their own.

---
 rtl/rca_seq_arbiter.sv | 140 ++++++++++++++
 tb/tb_rca_seq_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_seq_arbiter.sv
// Two-requester front end that shares one external N-bit adder, sequencing WORDS-wide adds LSW first.
// Optional signed overflow output enabled by defining RCA_SEQ_OVF_EN.
module rca_seq_arbiter #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [N*WORDS-1:0]   req0_a,
  input  logic [N*WORDS-1:0]   req0_b,
  input  logic                 req0_cin,
  input  logic [N*WORDS-1:0]   req1_a,
  input  logic [N*WORDS-1:0]   req1_b,
  input  logic                 req1_cin,
  output logic [N-1:0]         add_a,
  output logic [N-1:0]         add_b,
  output logic                 add_cin,
  input  logic [N-1:0]         add_sum,
  input  logic                 add_carry,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [N*WORDS-1:0]   rsp_sum,
  output logic                 rsp_carry,
`ifdef RCA_SEQ_OVF_EN
  output logic                 rsp_ovf,
`endif
  output logic                 busy
);

  // state | meaning
  // IDLE  | arbiter drives req_ready, waiting for a transfer
  // RUN   | one operand word per cycle through the external adder
  // DONE  | response held until rsp_ready
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int W  = N * WORDS;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [1:0]    state;
  logic [KW-1:0] k;
  logic [31:0]   base;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sum_q;
  logic          cin_q;
  logic          carry_q;
  logic          id_q;
  logic          last_q;
  logic [1:0]    grant;
  logic          accept;
  logic          sel;
  logic          last_word;
`ifdef RCA_SEQ_OVF_EN
  logic          ovf_q;
`endif

  // last_q resets to 1 so that requester 0 wins the first contention
  always_comb begin
    grant = req_valid;
    if (req_valid == 2'b11) grant = last_q ? 2'b01 : 2'b10;
  end

  assign req_ready = (state == IDLE && !rst) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign sel       = req_ready[1];
  assign base      = 32'(k) * 32'(N);
  assign last_word = (k == KW'(WORDS - 1));

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_q[base +: N];
      add_b   = b_q[base +: N];
      add_cin = (k == '0) ? cin_q : carry_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
`ifdef RCA_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q    <= sel ? req1_a : req0_a;
            b_q    <= sel ? req1_b : req0_b;
            cin_q  <= sel ? req1_cin : req0_cin;
            id_q   <= sel;
            last_q <= sel;
            k      <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          sum_q[base +: N] <= add_sum;
          carry_q          <= add_carry;
          k                <= k + KW'(1);
          if (last_word) begin
            state <= DONE;
`ifdef RCA_SEQ_OVF_EN
            ovf_q <= (add_a[N-1] == add_b[N-1]) && (add_sum[N-1] != add_a[N-1]);
`endif
          end
        end
        DONE: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = (state == DONE);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_carry = carry_q;
  assign busy      = (state != IDLE);
`ifdef RCA_SEQ_OVF_EN
  assign rsp_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_rca_seq_arbiter.sv
// Self-checking bench for rca_seq_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of arbitration, timing and W-bit modular addition.
module tb_rca_seq_arbiter;
  localparam int N     = 8;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready;
  logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic          req0_cin = 1'b0, req1_cin = 1'b0;
  logic [N-1:0]  add_a, add_b, add_sum;
  logic          add_cin, add_carry;
  logic          rsp_valid, rsp_id, rsp_carry, busy;
  logic          rsp_ready = 1'b1;
  logic [W-1:0]  rsp_sum;
`ifdef RCA_SEQ_OVF_EN
  logic          rsp_ovf;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_grant = 1;
  int grants[$];

  rca_seq_arbiter #(.N(N), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_carry(add_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_carry(rsp_carry),
`ifdef RCA_SEQ_OVF_EN
    .rsp_ovf(rsp_ovf),
`endif
    .busy(busy)
  );

  // external combinational ripple-carry adder
  assign {add_carry, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + (W+1)'(c);
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] s;
    s = ref_add(a, b, c);
    return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  // carry entering word k = carry out of the low k*N bits
  function automatic logic word_cin(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input int k);
    logic [W:0] m, s;
    if (k == 0) return c;
    m = ((W+1)'(1) << (k * N)) - (W+1)'(1);
    s = ({1'b0, a} & m) + ({1'b0, b} & m) + (W+1)'(c);
    return s[k * N];
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 3))
      0: return '1;
      1: return '0;
      default: return W'({$urandom(), $urandom()});
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_ops(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    if (id == 0) begin req0_a = a; req0_b = b; req0_cin = c; end
    else begin req1_a = a; req1_b = b; req1_cin = c; end
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    last_grant = 1;
  endtask

  // returns at the sample point of the first RUN cycle (cyc == t)
  task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic c, output int t);
    bit ok = 0;
    set_ops(id, a, b, c);
    req_valid[id] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (req_ready[id]) begin ok = 1; break; end
      tick();
    end
    t = cyc + 1;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL accept_timeout: requester %0d never got req_ready", id);
    end
    last_grant = id;
    tick();
    req_valid[id] = 1'b0;
    set_ops(id, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
    #1;
  endtask

  task automatic collect(input logic eid, input logic [W:0] es, input logic eovf, input int t);
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) break;
      tick();
      #1;
    end
    checks++;
    if (cyc - t !== WORDS) begin
      failures++;
      $display("FAIL latency: rsp_valid seen %0d cycles after accept, expected %0d", cyc - t, WORDS);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_sum !== es[W-1:0]) begin
      failures++;
      $display("FAIL rsp_sum: valid=%b got %h expected %h", rsp_valid, rsp_sum, es[W-1:0]);
    end
    checks++;
    if (rsp_carry !== es[W] || rsp_id !== eid) begin
      failures++;
      $display("FAIL rsp_carry_id: got carry=%b id=%b expected carry=%b id=%b", rsp_carry, rsp_id, es[W], eid);
    end
`ifdef RCA_SEQ_OVF_EN
    checks++;
    if (rsp_ovf !== eovf) begin
      failures++;
      $display("FAIL rsp_ovf: got %b expected %b", rsp_ovf, eovf);
    end
`else
    if (eovf === 1'bx) $display("note: overflow unknown");
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_ops(0, rnd_op(), rnd_op(), 1'b1);
    set_ops(1, rnd_op(), rnd_op(), 1'b1);
    req_valid = 2'b11;
    tick();
    #1;
    checks++;
    if ({req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_carry, busy} !== '0) begin
      failures++;
      $display("FAIL reset_values: ready=%b add_a=%h add_b=%h cin=%b valid=%b id=%b sum=%h carry=%b busy=%b",
               req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_carry, busy);
    end
    tick();
    rst = 1'b0;
    last_grant = 1;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL reset_pointer: req_ready=%b expected 01", req_ready);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_carry_chain();
    int t;
    tick();
    issue(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, t);
    collect(1'b0, ref_add(32'h0000_00FF, 32'h0000_0001, 1'b0), 1'b0, t);
  endtask

  task automatic test_full_carry();
    int t;
    tick();
    issue(1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, t);
    checks++;
    if (add_cin !== 1'b1 || add_a !== 8'hFF || add_b !== 8'h00) begin
      failures++;
      $display("FAIL first_run_cycle: add_cin=%b add_a=%h add_b=%h expected 1 ff 00", add_cin, add_a, add_b);
    end
    collect(1'b1, ref_add(32'hFFFF_FFFF, 32'h0, 1'b1), 1'b0, t);
  endtask

  task automatic test_backpressure();
    int t;
    logic [W-1:0] a, b, a1, b1;
    logic [W:0] es;
    bit bad = 0;
    a = rnd_op(); b = rnd_op();
    es = ref_add(a, b, 1'b0);
    tick();
    rsp_ready = 1'b0;
    issue(0, a, b, 1'b0, t);
    collect(1'b0, es, ref_ovf(a, b, 1'b0), t);
    a1 = rnd_op(); b1 = rnd_op();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) begin set_ops(1, a1, b1, 1'b1); req_valid[1] = 1'b1; end
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== es[W-1:0] || rsp_carry !== es[W] || rsp_id !== 1'b0 || req_ready !== 2'b00) begin
        failures++; bad = 1;
        $display("FAIL hold_in_done: valid=%b sum=%h carry=%b id=%b ready=%b", rsp_valid, rsp_sum, rsp_carry, rsp_id, req_ready);
      end
    end
    tick();
    rsp_ready = 1'b1;
    #1;
    tick();
    #1;
    checks++;
    if (busy !== 1'b0 || req_ready !== 2'b10) begin
      failures++;
      $display("FAIL idle_after_release: busy=%b req_ready=%b expected 0 10", busy, req_ready);
    end
    t = cyc + 1;
    last_grant = 1;
    tick();
    req_valid[1] = 1'b0;
    #1;
    collect(1'b1, ref_add(a1, b1, 1'b1), ref_ovf(a1, b1, 1'b1), t);
  endtask

  task automatic test_ovf();
    int t;
    tick();
    issue(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, t);
    collect(1'b0, {1'b0, 32'h8000_0000}, 1'b1, t);
  endtask

  task automatic test_reset_mid();
    int t;
    bit seen = 0;
    logic [W-1:0] a, b;
    tick();
    issue(0, rnd_op(), rnd_op(), 1'b1, t);
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_carry, busy} !== '0) begin
      failures++;
      $display("FAIL mid_run_reset: ready=%b add_a=%h add_b=%h cin=%b valid=%b id=%b sum=%h carry=%b busy=%b",
               req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_carry, busy);
    end
    tick();
    tick();
    rst = 1'b0;
    last_grant = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      #1;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL abandoned_op: response or busy observed after reset, got 1 expected 0");
    end
    a = rnd_op(); b = rnd_op();
    tick();
    issue(1, a, b, 1'b0, t);
    collect(1'b1, ref_add(a, b, 1'b0), ref_ovf(a, b, 1'b0), t);
  endtask

  // transaction-level model: IDLE sample may accept; then WORDS RUN samples; then DONE until rsp_ready
  task automatic run_model(input int cycles, input bit both);
    int run_left = 0;
    bit done = 0;
    bit acc[2] = '{0, 0};
    logic [W-1:0] ma = '0, mb = '0;
    logic mc = 1'b0;
    logic [W:0] es = '0;
    logic eid = 1'b0;
    int g, k;
    for (int c = 0; c < cycles; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          set_ops(i, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
          req_valid[i] = both;
          acc[i] = 0;
        end else if (!req_valid[i] && (both || $urandom_range(0, 2) == 0)) begin
          set_ops(i, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = both ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (run_left > 0) begin
        k = WORDS - run_left;
        if ({busy, rsp_valid, req_ready} !== 4'b1000 || add_a !== ma[k*N +: N] || add_b !== mb[k*N +: N]
            || add_cin !== word_cin(ma, mb, mc, k)) begin
          failures++;
          $display("FAIL model_run: word %0d busy=%b valid=%b ready=%b add=%h/%h/%b expected %h/%h/%b", k, busy,
                   rsp_valid, req_ready, add_a, add_b, add_cin, ma[k*N +: N], mb[k*N +: N], word_cin(ma, mb, mc, k));
        end
        run_left--;
        if (run_left == 0) done = 1;
      end else if (done) begin
        if ({busy, rsp_valid, req_ready} !== 4'b1100 || rsp_sum !== es[W-1:0] || rsp_carry !== es[W]
            || rsp_id !== eid || {add_a, add_b, add_cin} !== '0) begin
          failures++;
          $display("FAIL model_done: busy=%b valid=%b ready=%b sum=%h carry=%b id=%b expected sum=%h carry=%b id=%b",
                   busy, rsp_valid, req_ready, rsp_sum, rsp_carry, rsp_id, es[W-1:0], es[W], eid);
        end
`ifdef RCA_SEQ_OVF_EN
        checks++;
        if (rsp_ovf !== ref_ovf(ma, mb, mc)) begin
          failures++;
          $display("FAIL model_ovf: got %b expected %b", rsp_ovf, ref_ovf(ma, mb, mc));
        end
`endif
        if (rsp_ready) done = 0;
      end else begin
        if (req_valid == 2'b11) g = 1 - last_grant;
        else if (req_valid[0]) g = 0;
        else if (req_valid[1]) g = 1;
        else g = -1;
        if (req_ready !== ((g < 0) ? 2'b00 : 2'(1 << g)) || {busy, rsp_valid} !== 2'b00 || {add_a, add_b, add_cin} !== '0) begin
          failures++;
          $display("FAIL model_arb: valid=%b ready=%b busy=%b rsp_valid=%b expected grant %0d", req_valid, req_ready,
                   busy, rsp_valid, g);
        end
        if (g >= 0) begin
          ma = (g == 0) ? req0_a : req1_a;
          mb = (g == 0) ? req0_b : req1_b;
          mc = (g == 0) ? req0_cin : req1_cin;
          es = ref_add(ma, mb, mc);
          eid = 1'(g);
          last_grant = g;
          grants.push_back(g);
          acc[g] = 1;
          run_left = WORDS;
        end
      end
    end
  endtask

  task automatic test_contention();
    do_reset();
    grants.delete();
    run_model(40, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= grants.size() || grants[i] != (i % 2)) begin
        failures++;
        $display("FAIL grant_order[%0d]: got %0d expected %0d", i, (i < grants.size()) ? grants[i] : -1, i % 2);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    run_model(600, 1'b0);
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_full_carry();
    test_backpressure();
    test_ovf();
    test_reset_mid();
    test_contention();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
